axis_bram_adapter_s00_axis: RTL and testbench

AXI4-Stream slave front end of the AXIS-to-BRAM adapter. Accepts 32-bit stream words, holds them in a small internal FIFO, and presents them in order to the downstream buffer writer over a simple valid/accept handshake. The FIFO decouples upstream flow from downstream stalls; no word is ever dropped or duplicated.

---
 rtl/axis_bram_adapter_pkg.sv | 19 +
 rtl/axis_bram_adapter_fifo.sv | 69 ++++++
 rtl/axis_bram_adapter_s00_axis.sv | 57 +++++
 tb/tb_axis_bram_adapter_s00_axis.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/axis_bram_adapter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : axis_bram_adapter_pkg                                  |
// | Brief   : Shared defaults and helpers for the AXIS-to-BRAM path  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package axis_bram_adapter_pkg;

  localparam int C_DEFAULT_DATA_WIDTH = 32;
  localparam int C_DEFAULT_FIFO_DEPTH = 4;
  localparam int C_DEFAULT_PTR_WIDTH  = $clog2(C_DEFAULT_FIFO_DEPTH);

  // Pointer width for a power-of-two depth; wrap falls out of the width.
  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_bram_adapter_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : axis_bram_adapter_fifo                                 |
// | Brief   : Synchronous FIFO, combinational head read, clearing rst|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module axis_bram_adapter_fifo
  import axis_bram_adapter_pkg::*;
#(
  parameter int WIDTH = C_DEFAULT_DATA_WIDTH,
  parameter int DEPTH = C_DEFAULT_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_data,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [ptr_width(DEPTH):0]    o_count
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // Requests are qualified here so a caller can never over- or under-run.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/axis_bram_adapter_s00_axis.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : axis_bram_adapter_s00_axis                             |
// | Brief   : AXIS slave front end; maps handshakes onto a small FIFO|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module axis_bram_adapter_s00_axis
  import axis_bram_adapter_pkg::*;
#(
  parameter int C_S_AXIS_TDATA_WIDTH = C_DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH           = C_DEFAULT_FIFO_DEPTH
) (
  input  logic                              S_AXIS_ACLK,
  input  logic                              S_AXIS_ARESET,
  input  logic                              S_AXIS_TVALID,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
  input  logic                              S_AXIS_TLAST,
  output logic                              S_AXIS_TREADY,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]   DOUT_TO_BUF,
  output logic                              DOUT_VALID,
  input  logic                              DOUT_ACCEP
);

  logic                             w_full;
  logic                             w_empty;
  logic [ptr_width(FIFO_DEPTH):0]   w_count;
  logic                             w_push;
  logic                             w_pop;
  logic                             w_unused_ok;

  // Every beat is a full word and packet boundaries are not tracked here.
  assign w_unused_ok = ^{S_AXIS_TSTRB, S_AXIS_TLAST, w_count};

  // TREADY comes from registered state only, never from TVALID.
  assign S_AXIS_TREADY = !w_full && !S_AXIS_ARESET;
  assign DOUT_VALID    = !w_empty;
  assign w_push        = S_AXIS_TVALID && S_AXIS_TREADY;
  assign w_pop         = DOUT_VALID && DOUT_ACCEP;

  axis_bram_adapter_fifo #(
    .WIDTH (C_S_AXIS_TDATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (S_AXIS_ACLK),
    .rst     (S_AXIS_ARESET),
    .i_push  (w_push),
    .i_data  (S_AXIS_TDATA),
    .i_pop   (w_pop),
    .o_data  (DOUT_TO_BUF),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_axis_bram_adapter_s00_axis.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_axis_bram_adapter_s00_axis                          |
// | Brief   : Queue-model bench for the AXIS slave front end         |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_axis_bram_adapter_s00_axis;

  localparam int W = 32;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tvalid = 1'b0;
  logic [W-1:0] tdata = '0;
  logic [3:0]   tstrb = 4'hF;
  logic         tlast = 1'b0;
  logic         tready;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         accep = 1'b0;

  int vecs = 0;
  int errs = 0;
  bit started = 1'b0;

  logic [W-1:0] model_q [$];
  logic [W-1:0] got [$];
  logic [W-1:0] exp_q [$];

  always #5 clk = ~clk;

  axis_bram_adapter_s00_axis #(
    .C_S_AXIS_TDATA_WIDTH (W),
    .FIFO_DEPTH           (D)
  ) dut (
    .S_AXIS_ACLK   (clk),
    .S_AXIS_ARESET (rst),
    .S_AXIS_TVALID (tvalid),
    .S_AXIS_TDATA  (tdata),
    .S_AXIS_TSTRB  (tstrb),
    .S_AXIS_TLAST  (tlast),
    .S_AXIS_TREADY (tready),
    .DOUT_TO_BUF   (dout),
    .DOUT_VALID    (dout_valid),
    .DOUT_ACCEP    (accep)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Model: an ordered queue of at most D words; the head is the visible output.
  always @(posedge clk) begin
    bit m_push;
    bit m_pop;
    if (!rst && dout_valid && accep) got.push_back(dout);
    m_push = !rst && tvalid && (model_q.size() != D);
    m_pop  = !rst && accep && (model_q.size() != 0);
    if (rst) begin
      model_q.delete();
    end else begin
      if (m_pop) void'(model_q.pop_front());
      if (m_push) model_q.push_back(tdata);
    end
    #1;
    if (started) begin
      check("tready", W'(tready), W'(!rst && model_q.size() != D));
      check("dout_valid", W'(dout_valid), W'(model_q.size() != 0));
      if (model_q.size() != 0) check("dout_head", dout, model_q[0]);
      else if (rst) check("dout_reset", dout, '0);
    end
  end

  task automatic check_got(input string name);
    check({name, "_len"}, W'(got.size()), W'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check(name, got[i], exp_q[i]);
    got.delete();
  endtask

  // Offers words first..first+n-1, holding each until accepted.
  task automatic stream(input int first, input int n, input int acc_low,
                        input bit toggle, input bit last_on_final, input int drain);
    int  idx = 0;
    int  cyc = 0;
    bit  rdy;
    while (idx < n && cyc < 200) begin
      @(negedge clk);
      tvalid = 1'b1;
      tdata  = W'(first + idx);
      tlast  = last_on_final && (idx == n - 1);
      accep  = toggle ? cyc[0] : (cyc >= acc_low);
      rdy    = tready;
      @(posedge clk);
      if (rdy) idx++;
      cyc++;
    end
    if (idx < n) begin
      vecs++;
      errs++;
      $display("FAIL stream_timeout: sent %0d, expected %0d", idx, n);
    end
    if (drain > 0) begin
      @(negedge clk);
      tvalid = 1'b0;
      tlast  = 1'b0;
      accep  = 1'b1;
      repeat (drain) @(posedge clk);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    started = 1'b1;
    check("rst_valid", W'(dout_valid), '0);
    check("rst_tready", W'(tready), '0);
    check("rst_dout", dout, '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_tready", W'(tready), W'(1));
    check("post_rst_valid", W'(dout_valid), '0);

    // Streaming at full rate.
    stream(0, 3, 0, 1'b0, 1'b0, 3);
    exp_q = '{32'd0, 32'd1, 32'd2};
    check_got("stream");

    // Back-pressure: 3..6 fill the FIFO, 7 stalls until a pop.
    stream(3, 5, 6, 1'b0, 1'b0, 8);
    exp_q = '{32'd3, 32'd4, 32'd5, 32'd6, 32'd7};
    check_got("backpressure");

    // Drain with TLAST on the final word.
    stream(3, 3, 0, 1'b0, 1'b1, 6);
    exp_q = '{32'd3, 32'd4, 32'd5};
    check_got("drain");
    check("drain_valid", W'(dout_valid), '0);

    // Full with a simultaneous pop: no push that cycle.
    stream(16, 4, 100, 1'b0, 1'b0, 0);
    @(negedge clk);
    check("full_tready", W'(tready), '0);
    check("full_head", dout, W'(16));
    tvalid = 1'b1;
    tdata  = W'(20);
    accep  = 1'b1;
    @(negedge clk);
    check("full_pop_tready", W'(tready), W'(1));
    check("full_pop_head", dout, W'(17));
    tvalid = 1'b0;
    repeat (6) @(posedge clk);
    exp_q = '{32'd16, 32'd17, 32'd18, 32'd19};
    check_got("full");

    // Reset mid-operation discards stored words.
    stream(32, 3, 100, 1'b0, 1'b0, 0);
    @(negedge clk);
    rst    = 1'b1;
    tvalid = 1'b1;
    tdata  = W'(35);
    accep  = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_valid", W'(dout_valid), '0);
    check("midrst_dout", dout, '0);
    check("midrst_tready", W'(tready), '0);
    @(negedge clk);
    rst    = 1'b0;
    tvalid = 1'b0;
    accep  = 1'b1;
    #1;
    check("midrst_after_tready", W'(tready), W'(1));
    check("midrst_after_valid", W'(dout_valid), '0);
    repeat (4) @(posedge clk);
    exp_q.delete();
    check_got("midrst");

    // Wrap-around with DOUT_ACCEP toggling every cycle.
    stream(0, 10, 0, 1'b1, 1'b0, 8);
    exp_q.delete();
    for (int i = 0; i < 10; i++) exp_q.push_back(W'(i));
    check_got("wrap");

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
